rx_deserializer: RTL and testbench

Receive-side counterpart of the UART transmit path: recovers `{stop, data, start}` frames from the serial line, LSB first, one start bit and one stop bit. It synchronizes the asynchronous line, detects the start edge and samples each bit at mid-bit using a per-bit clock counter. It delivers each parallel byte with a one-cycle valid strobe and flags bad stop bits. It sits between the `rx` pad and the receive-side consumer (FIFO or register file).

---
 rtl/rx_deserializer.sv | 144 ++++++++++++++
 tb/tb_rx_deserializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_deserializer.sv
// UART-style receiver: synchronizes rx_in, samples each bit at mid-bit and
// delivers {stop, data, start} frames (LSB first) as parallel bytes.
module rx_deserializer #(
    parameter int FRAME_DATA   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [FRAME_DATA-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_error,
    output logic                  rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (FRAME_DATA > 1) ? $clog2(FRAME_DATA) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_DATA - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                  state, state_next;
    logic                    sync1, rx_s;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [IDX_W-1:0]        bit_idx, idx_next;
    logic [FRAME_DATA-1:0]   shreg, shreg_next;
    logic [FRAME_DATA-1:0]   data_next;
    logic                    valid_next, ferr_next;

    // Idle-high line: both synchronizer stages reset to 1 so reset itself
    // never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            bit_idx     <= idx_next;
            shreg       <= shreg_next;
            rx_data     <= data_next;
            rx_valid    <= valid_next;
            frame_error <= ferr_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = bit_idx;
        shreg_next = shreg;
        data_next  = rx_data;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (!rx_s) state_next = S_START;
            end

            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next = S_DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_s, shreg[FRAME_DATA-1:1]};
                    if (bit_idx == IDX_LAST) state_next = S_STOP;
                    else                     idx_next   = bit_idx + 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_STOP: begin
                // Leaving at mid stop bit gives half a bit of slack for a
                // start bit that follows immediately.
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shreg;
                        valid_next = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = S_BREAK;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_BREAK: begin
                cnt_next = '0;
                if (rx_s) state_next = S_IDLE;
            end

            default: state_next = S_IDLE;
        endcase
    end

    assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_rx_deserializer.sv
// Scoreboard bench for rx_deserializer at CLKS_PER_BIT=8, FRAME_DATA=8:
// each driven frame pushes its expected byte, kind and pulse cycle.
module tb_rx_deserializer;

    localparam int CPB = 8;
    localparam int FD  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic [FD-1:0] rx_data;
    logic          rx_valid;
    logic          frame_error;
    logic          rx_busy;

    rx_deserializer #(.FRAME_DATA(FD), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;
    logic       busy_q = 1'b0;
    int         busy_rises = 0;
    int         busy_rise_cyc = 0;
    int         busy_fall_cyc = 0;
    int         valid_count = 0;
    int         ferr_count = 0;
    int         last_valid_cyc = 0;
    int         prev_valid_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: compares every pulse against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst) last_good = 8'h00;
        if (rx_busy && !busy_q) begin
            busy_rises++;
            busy_rise_cyc = cyc;
        end
        if (!rx_busy && busy_q) busy_fall_cyc = cyc;
        busy_q = rx_busy;
        if (rx_valid || frame_error) begin
            check("exclusive", 32'(rx_valid & frame_error), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {24'd0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("pulse_cyc", 32'(cyc), 32'(e.cyc));
                check("pulse_kind", 32'(frame_error), 32'(e.err));
                if (rx_valid) begin
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    last_good      = e.data;
                    valid_count++;
                    prev_valid_cyc = last_valid_cyc;
                    last_valid_cyc = cyc;
                end else begin
                    check("rx_data_hold", 32'(rx_data), 32'(last_good));
                    ferr_count++;
                end
            end
        end
    end

    // Called right after a posedge; returns just after the posedge that ends
    // the stop bit, so frames can be chained with no idle gap.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int n);
        exp_t e;
        #1;
        rx_in  = 1'b0;
        n      = cyc;
        e.data = d;
        e.err  = ~stop_bit;
        e.cyc  = n + 79;
        sb.push_back(e);
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < FD; i++) begin
            #1 rx_in = d[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx_in = stop_bit;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic idle(input int cycles);
        #1 rx_in = 1'b1;
        repeat (cycles) @(posedge clk);
    endtask

    initial begin
        int         n, n1, n2, r0;
        logic [7:0] part;

        rx_in = 1'b1;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        check("rst_rx_busy", 32'(rx_busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        idle(10);

        // Single frame
        send_frame(8'hA5, 1'b1, n);
        check("single_busy_rise", 32'(busy_rise_cyc), 32'(n + 3));
        check("single_busy_fall", 32'(busy_fall_cyc), 32'(n + 79));
        check("single_valid_count", 32'(valid_count), 32'd1);
        idle(16);

        // Glitch rejection
        r0 = busy_rises;
        #1 rx_in = 1'b0;
        repeat (2) @(posedge clk);
        idle(100);
        @(negedge clk);
        check("glitch_busy_rises", 32'(busy_rises - r0), 32'd1);
        check("glitch_busy_idle", 32'(rx_busy), 32'd0);
        check("glitch_rx_data", 32'(rx_data), 32'hA5);
        check("glitch_valid_count", 32'(valid_count), 32'd1);
        @(posedge clk);

        // Framing error, held break, then recovery
        send_frame(8'h3C, 1'b0, n);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("break_busy", 32'(rx_busy), 32'd1);
        check("break_ferr_count", 32'(ferr_count), 32'd1);
        check("break_rx_data", 32'(rx_data), 32'hA5);
        @(posedge clk);
        idle(16);
        @(negedge clk);
        check("break_exit", 32'(rx_busy), 32'd0);
        @(posedge clk);
        send_frame(8'h01, 1'b1, n);
        idle(16);
        check("recover_valid_count", 32'(valid_count), 32'd2);

        // Back-to-back
        send_frame(8'h00, 1'b1, n1);
        send_frame(8'hFF, 1'b1, n2);
        idle(16);
        check("b2b_start_gap", 32'(n2 - n1), 32'd80);
        check("b2b_pulse_gap", 32'(last_valid_cyc - prev_valid_cyc), 32'd80);
        check("b2b_valid_count", 32'(valid_count), 32'd4);

        // Reset mid-frame during data bit 4 of 0x96
        part = 8'h96;
        #1 rx_in = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rx_in = part[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx_in = part[4];
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_frame_error", 32'(frame_error), 32'd0);
        check("midrst_rx_busy", 32'(rx_busy), 32'd0);
        @(posedge clk);
        idle(20);
        send_frame(8'h5A, 1'b1, n);
        idle(16);
        check("midrst_valid_count", 32'(valid_count), 32'd5);
        check("midrst_final_data", 32'(rx_data), 32'h5A);
        check("total_ferr_count", 32'(ferr_count), 32'd1);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
